// File: rtl/demo_arb_pkg.sv
// Shared types and the round-robin pick function for the bus host arbiter.
package demo_arb_pkg;

  // Default build point, used for the documented host index and request types
  localparam int NumHostsPkg  = 2;
  localparam int AddrWidthPkg = 32;
  localparam int DataWidthPkg = 32;

  // Upper bound on hosts the pick function can scan
  localparam int MaxHosts = 16;

  typedef logic [$clog2(NumHostsPkg)-1:0] host_idx_t;

  typedef struct packed {
    logic                      we;
    logic [DataWidthPkg/8-1:0] be;
    logic [AddrWidthPkg-1:0]   addr;
    logic [DataWidthPkg-1:0]   wdata;
  } bus_req_t;

  // First requesting host strictly after ptr, wrapping over n hosts; ptr if nobody requests
  function automatic int unsigned rr_pick(input logic [MaxHosts-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned res;
    int unsigned idx;
    logic        found;
    res   = ptr;
    found = 1'b0;
    for (int unsigned off = 1; off <= n; off++) begin
      idx = (ptr + off) % n;
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demo_arb_owner_fifo.sv
// Owner FIFO: remembers which host issued each outstanding transaction, in accept order.
module demo_arb_owner_fifo
  import demo_arb_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic             err_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign err_o   = (push_i && full_o) || (pop_i && empty_o);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy; push and pop may share a cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state is reset; storage contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage update
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/demo_bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between several bus hosts.
// Requests pass through combinationally; responses are steered back via the owner FIFO.
module demo_bus_host_arbiter
  import demo_arb_pkg::*;
#(
  parameter int NumHosts       = 2,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1,
  localparam int BeW  = DataWidth / 8
) (
  input  logic                                clk_sys_i,
  input  logic                                rst_sys_i,
  input  logic [NumHosts-1:0]                 host_req_i,
  input  logic [NumHosts-1:0]                 host_we_i,
  input  logic [NumHosts-1:0][BeW-1:0]        host_be_i,
  input  logic [NumHosts-1:0][AddrWidth-1:0]  host_addr_i,
  input  logic [NumHosts-1:0][DataWidth-1:0]  host_wdata_i,
  output logic [NumHosts-1:0]                 host_gnt_o,
  output logic [NumHosts-1:0]                 host_rvalid_o,
  output logic [NumHosts-1:0][DataWidth-1:0]  host_rdata_o,
  output logic [NumHosts-1:0]                 host_err_o,
  output logic                                dev_req_o,
  output logic                                dev_we_o,
  output logic [BeW-1:0]                      dev_be_o,
  output logic [AddrWidth-1:0]                dev_addr_o,
  output logic [DataWidth-1:0]                dev_wdata_o,
  input  logic                                dev_gnt_i,
  input  logic                                dev_rvalid_i,
  input  logic [DataWidth-1:0]                dev_rdata_i,
  input  logic                                dev_err_i,
  output logic                                unexpected_rsp_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0]     rr_q, rr_d;
  logic                lock_q, lock_d;
  logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
  logic                unexpected_q, unexpected_d;
  logic [IdxW-1:0]     pick, winner, head;
  logic [MaxHosts-1:0] req_pad;
  logic                accept, pop;
  logic                fifo_full, fifo_empty, fifo_err;
  logic [CntW-1:0]     fifo_count;

  assign req_pad = MaxHosts'(host_req_i);

  // Winner selection: a locked winner holds until granted, otherwise round-robin pick
  always_comb begin
    pick   = IdxW'(rr_pick(req_pad, 32'(rr_q), NumHosts));
    winner = lock_q ? lock_idx_q : pick;
  end

  // Device request and payload mux; payload is driven to zero when not requesting
  always_comb begin
    dev_req_o   = (|host_req_i) && !fifo_full && !rst_sys_i;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    if (dev_req_o) begin
      dev_we_o    = host_we_i[winner];
      dev_be_o    = host_be_i[winner];
      dev_addr_o  = host_addr_i[winner];
      dev_wdata_o = host_wdata_i[winner];
    end
  end

  assign accept = dev_req_o && dev_gnt_i;
  assign pop    = dev_rvalid_i && !fifo_empty && !rst_sys_i;

  // Per-host grant and response steering; read data is broadcast to every host
  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      host_gnt_o[i]    = accept && (winner == IdxW'(i));
      host_rvalid_o[i] = pop && (head == IdxW'(i));
      host_err_o[i]    = pop && (head == IdxW'(i)) && dev_err_i;
      host_rdata_o[i]  = dev_rdata_i;
    end
  end

  assign unexpected_rsp_o = unexpected_q;

  // Next-state for pointer, lock and the sticky unexpected-response flag
  always_comb begin
    rr_d         = accept ? winner : rr_q;
    lock_d       = dev_req_o && !dev_gnt_i;
    lock_idx_d   = lock_d ? winner : lock_idx_q;
    unexpected_d = unexpected_q | (dev_rvalid_i && fifo_empty);
  end

  // Control registers; rr pointer starts at the last host so host 0 wins first
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rr_q         <= IdxW'(NumHosts - 1);
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      unexpected_q <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      unexpected_q <= unexpected_d;
    end
  end

  demo_arb_owner_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_owner_fifo (
    .clk_i   (clk_sys_i),
    .rst_i   (rst_sys_i),
    .push_i  (accept),
    .wdata_i (winner),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .err_o   (fifo_err)
  );

  a_payload_stable: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
    (dev_req_o && !dev_gnt_i) |=> (dev_req_o &&
      $stable({dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o})));

  a_gnt_onehot: assert property (@(posedge clk_sys_i) $onehot0(host_gnt_o));

  a_rvalid_onehot: assert property (@(posedge clk_sys_i) $onehot0(host_rvalid_o));

  a_locked_req_held: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
    lock_q |-> host_req_i[lock_idx_q]);

  a_fifo_ok: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i) !fifo_err);

  a_count_bound: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
    fifo_count <= CntW'(MaxOutstanding));

endmodule
